// File: rtl/ddr2_cfg_pkg.sv
// Shared definitions for the DDR2 APB config slave: register offsets, field
// layouts, reset values and the transfer state encoding.
package ddr2_cfg_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 4;

  // Register byte offsets
  localparam logic [7:0] OFF_CTRL    = 8'h00;
  localparam logic [7:0] OFF_STATUS  = 8'h04;
  localparam logic [7:0] OFF_TIMING0 = 8'h08;
  localparam logic [7:0] OFF_TIMING1 = 8'h0C;
  localparam logic [7:0] OFF_SCRATCH = 8'h10;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } apb_state_e;

  typedef struct packed {
    logic auto_ref_en;
    logic init_start;
  } ctrl_t;

  typedef struct packed {
    logic [4:0] t_ras;
    logic [3:0] t_rp;
    logic [3:0] t_rcd;
  } timing0_t;

  typedef struct packed {
    logic [15:0] t_refi;
    logic [7:0]  t_rfc;
  } timing1_t;

  localparam logic        AUTO_REF_RST = 1'b1;
  localparam timing0_t    TIMING0_RST  = '{t_ras: 5'd9, t_rp: 4'd3, t_rcd: 4'd3};
  localparam timing1_t    TIMING1_RST  = '{t_refi: 16'd1560, t_rfc: 8'd21};
  localparam logic [31:0] SCRATCH_RST  = 32'h0;

endpackage

// File: rtl/ddr2_apb_cfg_slave_if.sv
// APB bus bundle between host (master) and the DDR2 config slave.
// Signals: psel/penable/paddr/pwrite/pwdata from master; pready/prdata/pslverr back.
interface ddr2_apb_cfg_slave_if #(
  parameter int unsigned ADDR_WIDTH = 32
);
  logic                  psel;
  logic                  penable;
  logic [ADDR_WIDTH-1:0] paddr;
  logic                  pwrite;
  logic [31:0]           pwdata;
  logic                  pready;
  logic [31:0]           prdata;
  logic                  pslverr;

  modport master (
    output psel, penable, paddr, pwrite, pwdata,
    input  pready, prdata, pslverr
  );

  modport slave (
    input  psel, penable, paddr, pwrite, pwdata,
    output pready, prdata, pslverr
  );
endinterface

// File: rtl/ddr2_apb_slv_fsm.sv
// APB setup/access sequencer with programmable wait states and abort on psel drop.
// Inputs: clk, rst, psel, penable, paddr, pwrite, pwdata.
// Outputs: done_c/rd_en_c/wr_en_c (completion strobes, combinational),
//          addr/wdata/is_write (transfer latched at setup).
module ddr2_apb_slv_fsm
  import ddr2_cfg_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 0,
  parameter int unsigned ADDR_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  psel,
  input  logic                  penable,
  input  logic [ADDR_WIDTH-1:0] paddr,
  input  logic                  pwrite,
  input  logic [31:0]           pwdata,
  output logic                  done_c,
  output logic                  rd_en_c,
  output logic                  wr_en_c,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [31:0]           wdata,
  output logic                  is_write
);

  localparam logic [0:0]       IDLE     = ST_IDLE;
  localparam logic [0:0]       ACCESS   = ST_ACCESS;
  localparam logic [CNT_W-1:0] WAIT_LIM = CNT_W'(WAIT_CYCLES);

  logic [0:0]       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             setup_c;

  assign setup_c = (state == IDLE) && psel && !penable;

  // State, counter and setup-phase latch
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      addr     <= '0;
      wdata    <= '0;
      is_write <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (setup_c) begin
        addr     <= paddr;
        wdata    <= pwdata;
        is_write <= pwrite;
      end
    end
  end

  // Next state; access without a preceding setup is ignored in IDLE
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    done_c    = 1'b0;
    case (state)
      IDLE: begin
        if (setup_c) begin
          state_nxt = ACCESS;
          cnt_nxt   = '0;
        end
      end
      ACCESS: begin
        if (!psel) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (penable) begin
          if (cnt == WAIT_LIM) begin
            done_c    = 1'b1;
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign rd_en_c = done_c & ~is_write;
  assign wr_en_c = done_c & is_write;

endmodule

// File: rtl/ddr2_apb_cfg_slave.sv
// DDR2 controller config/status register block behind an APB slave port.
// Ports: clk, rst (sync, active-high), apb (slave modport), init_done_i/busy_i
// status in; init_start_o pulse, auto_ref_en_o and timing fields out.
module ddr2_apb_cfg_slave
  import ddr2_cfg_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 0,
  parameter int unsigned ADDR_WIDTH  = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  ddr2_apb_cfg_slave_if.slave        apb,
  input  logic                       init_done_i,
  input  logic                       busy_i,
  output logic                       init_start_o,
  output logic                       auto_ref_en_o,
  output logic [3:0]                 t_rcd_o,
  output logic [3:0]                 t_rp_o,
  output logic [4:0]                 t_ras_o,
  output logic [7:0]                 t_rfc_o,
  output logic [15:0]                t_refi_o
);

  logic                  done_c, rd_en_c, wr_en_c, is_write;
  logic [ADDR_WIDTH-1:0] addr;
  logic [31:0]           wdata;

  ddr2_apb_slv_fsm #(
    .WAIT_CYCLES (WAIT_CYCLES),
    .ADDR_WIDTH  (ADDR_WIDTH)
  ) u_fsm (
    .clk      (clk),
    .rst      (rst),
    .psel     (apb.psel),
    .penable  (apb.penable),
    .paddr    (apb.paddr),
    .pwrite   (apb.pwrite),
    .pwdata   (apb.pwdata),
    .done_c   (done_c),
    .rd_en_c  (rd_en_c),
    .wr_en_c  (wr_en_c),
    .addr     (addr),
    .wdata    (wdata),
    .is_write (is_write)
  );

  logic        auto_ref_q;
  timing0_t    t0_q;
  timing1_t    t1_q;
  logic [31:0] scratch_q;
  logic        init_start_q;

  logic [7:0]  off_c;
  logic [31:0] rd_val_c;
  logic        mapped_c, err_c, commit_c;
  ctrl_t       wr_ctrl_c;

  assign off_c     = addr[7:0];
  assign wr_ctrl_c = ctrl_t'(wdata[1:0]);

  // Read mux and offset decode
  always_comb begin
    rd_val_c = '0;
    mapped_c = 1'b1;
    case (off_c)
      OFF_CTRL:    rd_val_c = 32'({auto_ref_q, 1'b0});
      OFF_STATUS:  rd_val_c = 32'({busy_i, init_done_i});
      OFF_TIMING0: rd_val_c = 32'(t0_q);
      OFF_TIMING1: rd_val_c = 32'(t1_q);
      OFF_SCRATCH: rd_val_c = scratch_q;
      default:     mapped_c = 1'b0;
    endcase
  end

  assign err_c = !mapped_c || (addr[1:0] != 2'b00) || (|addr[ADDR_WIDTH-1:8]) ||
                 (is_write && (off_c == OFF_STATUS));
  assign commit_c = wr_en_c && !err_c;

  assign apb.pready  = done_c;
  assign apb.pslverr = done_c && err_c;
  assign apb.prdata  = (rd_en_c && !err_c) ? rd_val_c : 32'h0;

  // Register file; init_start is a one-cycle pulse after a committed CTRL write
  always_ff @(posedge clk) begin
    if (rst) begin
      auto_ref_q   <= AUTO_REF_RST;
      t0_q         <= TIMING0_RST;
      t1_q         <= TIMING1_RST;
      scratch_q    <= SCRATCH_RST;
      init_start_q <= 1'b0;
    end else begin
      init_start_q <= 1'b0;
      if (commit_c) begin
        case (off_c)
          OFF_CTRL: begin
            auto_ref_q   <= wr_ctrl_c.auto_ref_en;
            init_start_q <= wr_ctrl_c.init_start;
          end
          OFF_TIMING0: t0_q      <= timing0_t'(wdata[12:0]);
          OFF_TIMING1: t1_q      <= timing1_t'(wdata[23:0]);
          OFF_SCRATCH: scratch_q <= wdata;
          default: ;
        endcase
      end
    end
  end

  assign init_start_o  = init_start_q;
  assign auto_ref_en_o = auto_ref_q;
  assign t_rcd_o       = t0_q.t_rcd;
  assign t_rp_o        = t0_q.t_rp;
  assign t_ras_o       = t0_q.t_ras;
  assign t_rfc_o       = t1_q.t_rfc;
  assign t_refi_o      = t1_q.t_refi;

endmodule

// File: tb/tb_ddr2_apb_cfg_slave.sv
// Randomized + directed bench for ddr2_apb_cfg_slave against a register-map model.
module tb_ddr2_apb_cfg_slave;

  localparam int unsigned WAIT = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic init_done_i = 1'b0;
  logic busy_i = 1'b0;
  logic init_start_o, auto_ref_en_o;
  logic [3:0]  t_rcd_o, t_rp_o;
  logic [4:0]  t_ras_o;
  logic [7:0]  t_rfc_o;
  logic [15:0] t_refi_o;

  ddr2_apb_cfg_slave_if #(.ADDR_WIDTH(32)) apb ();

  ddr2_apb_cfg_slave #(.WAIT_CYCLES(WAIT), .ADDR_WIDTH(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .apb           (apb),
    .init_done_i   (init_done_i),
    .busy_i        (busy_i),
    .init_start_o  (init_start_o),
    .auto_ref_en_o (auto_ref_en_o),
    .t_rcd_o       (t_rcd_o),
    .t_rp_o        (t_rp_o),
    .t_ras_o       (t_ras_o),
    .t_rfc_o       (t_rfc_o),
    .t_refi_o      (t_refi_o)
  );

  always #5 clk = ~clk;

  // Register-map model
  logic        m_auto_ref;
  logic [12:0] m_t0;
  logic [23:0] m_t1;
  logic [31:0] m_scr;

  // Expected bus/pulse values for the current cycle
  logic        exp_pready, exp_err, exp_prd_chk, exp_init_start;
  logic [31:0] exp_prdata;
  logic        lit_valid, lit_err;
  logic [31:0] lit_data;

  logic        pend_commit, pend_pulse;
  logic [31:0] pend_addr, pend_data;
  logic        chk_en = 1'b0;
  logic        force_st = 1'b0;
  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;

  task automatic model_reset();
    m_auto_ref = 1'b1;
    m_t0 = {5'd9, 4'd3, 4'd3};
    m_t1 = {16'd1560, 8'd21};
    m_scr = 32'h0;
  endtask

  function automatic logic map_err(input logic [31:0] a, input logic w);
    if (a[31:8] != 24'h0 || a[1:0] != 2'b00) return 1'b1;
    if (a[7:0] > 8'h10) return 1'b1;
    if (w && a[7:0] == 8'h04) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    case (a[7:0])
      8'h00:   return {30'h0, m_auto_ref, 1'b0};
      8'h04:   return {30'h0, busy_i, init_done_i};
      8'h08:   return {19'h0, m_t0};
      8'h0C:   return {8'h0, m_t1};
      default: return m_scr;
    endcase
  endfunction

  task automatic model_write(input logic [31:0] a, input logic [31:0] d);
    case (a[7:0])
      8'h00: begin m_auto_ref = d[1]; pend_pulse = d[0]; end
      8'h08: m_t0 = d[12:0];
      8'h0C: m_t1 = d[23:0];
      8'h10: m_scr = d;
      default: ;
    endcase
  endtask

  // Advance one cycle: apply reset or pending commit seen at this edge, clear expectations
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    exp_init_start = 1'b0;
    if (rst) begin
      model_reset();
    end else if (pend_commit) begin
      pend_pulse = 1'b0;
      model_write(pend_addr, pend_data);
      exp_init_start = pend_pulse;
    end
    pend_commit = 1'b0;
    exp_pready = 1'b0; exp_err = 1'b0; exp_prdata = 32'h0; exp_prd_chk = 1'b1;
    lit_valid = 1'b0;
    apb.psel = 1'b0; apb.penable = 1'b0;
    if (force_st) begin
      init_done_i = 1'b1; busy_i = 1'b0;
    end else begin
      init_done_i = 1'($urandom_range(0, 1));
      busy_i      = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, act, exp);
    end
  endtask

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("pready", 32'(apb.pready), 32'(exp_pready));
      chk("pslverr", 32'(apb.pslverr), 32'(exp_err));
      if (exp_prd_chk) chk("prdata", apb.prdata, exp_prdata);
      chk("init_start_o", 32'(init_start_o), 32'(exp_init_start));
      chk("auto_ref_en_o", 32'(auto_ref_en_o), 32'(m_auto_ref));
      chk("t_rcd_o", 32'(t_rcd_o), 32'(m_t0[3:0]));
      chk("t_rp_o", 32'(t_rp_o), 32'(m_t0[7:4]));
      chk("t_ras_o", 32'(t_ras_o), 32'(m_t0[12:8]));
      chk("t_rfc_o", 32'(t_rfc_o), 32'(m_t1[7:0]));
      chk("t_refi_o", 32'(t_refi_o), 32'(m_t1[23:8]));
      if (lit_valid) begin
        chk("lit_pslverr", 32'(apb.pslverr), 32'(lit_err));
        chk("lit_prdata", apb.prdata, lit_data);
      end
    end
  end

  // One APB transfer; abort_at/rst_at select an access cycle (1-based) to drop psel or assert rst
  task automatic xfer(input logic [31:0] a, input logic w, input logic [31:0] d,
                      input int abort_at, input int rst_at,
                      input logic lchk, input logic lerr, input logic [31:0] ldata);
    logic dead = 1'b0;
    logic err;
    step();
    apb.psel = 1'b1; apb.penable = 1'b0; apb.paddr = a; apb.pwrite = w; apb.pwdata = d;
    for (int k = 1; k <= int'(WAIT) + 1; k++) begin
      step();
      if (dead) begin
        rst = 1'b0;
        apb.psel = 1'b1; apb.penable = 1'b1;
        continue;
      end
      if (k == abort_at) return;
      apb.psel = 1'b1; apb.penable = 1'b1;
      if (k == rst_at) begin
        rst = 1'b1;
        dead = 1'b1;
        continue;
      end
      if (k == int'(WAIT) + 1) begin
        err = map_err(a, w);
        exp_pready  = 1'b1;
        exp_err     = err;
        exp_prdata  = (!w && !err) ? model_read(a) : 32'h0;
        exp_prd_chk = !w || err;
        pend_commit = w && !err;
        pend_addr   = a;
        pend_data   = d;
        lit_valid   = lchk;
        lit_err     = lerr;
        lit_data    = ldata;
      end
    end
  endtask

  function automatic logic [31:0] rand_addr();
    int unsigned s = $urandom_range(0, 9);
    logic [31:0] r = $urandom;
    case (s)
      0, 1, 2, 3, 4: return 32'(s * 4);
      5:       return 32'h14;
      6:       return 32'h09;
      7:       return 32'h0000_0108;
      8:       return r;
      default: return {24'h0, r[7:2], 2'b00};
    endcase
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog cyc=%0d got=running exp=finished", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] a, d;
    logic w;
    int r, ab, rk;
    apb.psel = 1'b0; apb.penable = 1'b0; apb.paddr = '0; apb.pwrite = 1'b0; apb.pwdata = '0;
    pend_commit = 1'b0; pend_pulse = 1'b0; pend_addr = '0; pend_data = '0;
    model_reset();
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    chk_en = 1'b1;

    // Reset values through reads
    xfer(32'h08, 1'b0, 32'h0, 0, 0, 1'b1, 1'b0, 32'h0000_0933);
    xfer(32'h0C, 1'b0, 32'h0, 0, 0, 1'b1, 1'b0, 32'h0006_1815);
    xfer(32'h00, 1'b0, 32'h0, 0, 0, 1'b1, 1'b0, 32'h0000_0002);
    // Scratch write/readback with wait states
    xfer(32'h10, 1'b1, 32'hDEAD_BEEF, 0, 0, 1'b0, 1'b0, 32'h0);
    xfer(32'h10, 1'b0, 32'h0, 0, 0, 1'b1, 1'b0, 32'hDEAD_BEEF);
    // Init start pulse; CTRL[0] reads back 0
    xfer(32'h00, 1'b1, 32'h0000_0003, 0, 0, 1'b0, 1'b0, 32'h0);
    xfer(32'h00, 1'b0, 32'h0, 0, 0, 1'b1, 1'b0, 32'h0000_0002);
    // Error accesses
    xfer(32'h04, 1'b1, 32'hFFFF_FFFF, 0, 0, 1'b1, 1'b1, 32'h0);
    xfer(32'h14, 1'b0, 32'h0, 0, 0, 1'b1, 1'b1, 32'h0);
    xfer(32'h09, 1'b0, 32'h0, 0, 0, 1'b1, 1'b1, 32'h0);
    xfer(32'h0000_0110, 1'b1, 32'h1234_5678, 0, 0, 1'b1, 1'b1, 32'h0);
    xfer(32'h10, 1'b0, 32'h0, 0, 0, 1'b1, 1'b0, 32'hDEAD_BEEF);
    // Abort mid-wait, then reset mid-access
    xfer(32'h08, 1'b1, 32'h0000_1FFF, 2, 0, 1'b0, 1'b0, 32'h0);
    xfer(32'h08, 1'b0, 32'h0, 0, 0, 1'b1, 1'b0, 32'h0000_0933);
    xfer(32'h0C, 1'b1, 32'h00FF_FFFF, 0, 2, 1'b0, 1'b0, 32'h0);
    xfer(32'h10, 1'b0, 32'h0, 0, 0, 1'b1, 1'b0, 32'h0);
    xfer(32'h0C, 1'b0, 32'h0, 0, 0, 1'b1, 1'b0, 32'h0006_1815);
    // Back-to-back write then status read
    force_st = 1'b1;
    xfer(32'h0C, 1'b1, 32'h00AB_CD12, 0, 0, 1'b0, 1'b0, 32'h0);
    xfer(32'h04, 1'b0, 32'h0, 0, 0, 1'b1, 1'b0, 32'h0000_0001);
    force_st = 1'b0;
    xfer(32'h0C, 1'b0, 32'h0, 0, 0, 1'b1, 1'b0, 32'h00AB_CD12);

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      r  = int'($urandom_range(0, 99));
      a  = rand_addr();
      w  = 1'($urandom_range(0, 1));
      d  = $urandom;
      ab = (r < 10) ? int'($urandom_range(1, WAIT + 1)) : 0;
      rk = (r >= 97) ? int'($urandom_range(1, WAIT)) : 0;
      xfer(a, w, d, ab, rk, 1'b0, 1'b0, 32'h0);
      repeat ($urandom_range(0, 2)) begin
        step();
        if ($urandom_range(0, 4) == 0) begin
          apb.psel = 1'b1; apb.penable = 1'b1;
        end
      end
    end

    step(); step();
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
